// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> sequential imem word writes, CPU held in reset until done.
// Optional trailing XOR checksum byte when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state, w_next, w_tail;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_word;
  logic              r_rx_ready, r_we, r_cpu_rst, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              w_busy_n, w_done_n, w_err_n;

  logic [15:0] w_n;
  logic        w_acc, w_ovf, w_last, w_word_done, w_start_ok;

  assign w_acc       = i_rx_valid && r_rx_ready;
  assign w_n         = {i_rx_data, r_len[7:0]};
  assign w_ovf       = {1'b0, w_n} > (17'd1 << ADDR_W);
  assign w_last      = 16'(r_idx) == (r_len - 16'd1);
  assign w_word_done = w_acc && (r_state == S_DATA) && (r_bcnt == 2'd3);
  assign w_start_ok  = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] r_cksum;
  assign w_tail = S_CKSUM;
`else
  assign w_tail = S_DONE;
`endif

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_LEN0;
      S_LEN0: if (w_acc) w_next = S_LEN1;
      S_LEN1: if (w_acc) begin
        if (w_ovf)           w_next = S_ERR;
        else if (w_n == '0)  w_next = w_tail;
        else                 w_next = S_DATA;
      end
      S_DATA: if (w_word_done && w_last) w_next = w_tail;
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: if (w_acc) w_next = (i_rx_data == r_cksum) ? S_DONE : S_ERR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the next state so the registered copies line up with it
  always_comb begin
    w_done_n = (w_next == S_DONE);
    w_err_n  = (w_next == S_ERR);
    w_busy_n = (w_next == S_LEN0) || (w_next == S_LEN1) || (w_next == S_DATA)
`ifdef IMEM_LOADER_CKSUM_EN
            || (w_next == S_CKSUM)
`endif
            ;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_ready <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_ready <= w_busy_n;
      r_cpu_rst  <= !w_done_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
    end
  end

  // Datapath: length capture, word assembly, write port
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      r_cksum <= '0;
`endif
    end else begin
      r_we <= w_word_done;
      if (w_word_done) begin
        r_addr  <= r_idx;
        r_wdata <= {i_rx_data, r_word};
      end
      if (w_start_ok) begin
        r_idx  <= '0;
        r_bcnt <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
        r_cksum <= '0;
`endif
      end else if (w_acc) begin
        case (r_state)
          S_LEN0: r_len[7:0]  <= i_rx_data;
          S_LEN1: r_len[15:8] <= i_rx_data;
          S_DATA: begin
            r_word <= {i_rx_data, r_word[23:8]};
            r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            r_cksum <= r_cksum ^ i_rx_data;
`endif
            // index parks on the last word rather than wrapping
            if (r_bcnt == 2'd3 && !w_last) r_idx <= r_idx + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_busy       = r_rx_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; image/expectations built from the byte-stream format.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready, we, cpu_rst, busy, done, err;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;

  int checks = 0, failures = 0;
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_rx_ready(rx_ready), .o_imem_we(we), .o_imem_addr(addr), .o_imem_wdata(wdata),
    .o_cpu_rst(cpu_rst), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (we) begin
    got_addr.push_back(addr);
    got_data.push_back(wdata);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    repeat (gap) begin
      @(negedge clk); rx_valid = 1'b0; rx_data = 8'($urandom);
    end
    @(negedge clk); rx_valid = 1'b1; rx_data = b; if (pulse) start = 1'b1;
    for (int t = 0; ; t++) begin
      if (rx_ready) begin @(posedge clk); #1 start = 1'b0; break; end
      if (t >= 64) begin
        checks++; failures++;
        $display("FAIL byte_timeout: rx_ready=%0b after %0d cycles, need 1", rx_ready, t);
        rx_valid = 1'b0; start = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_start(input string name);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if ({rx_ready, busy, done, err, cpu_rst} !== 5'b11001)
      $display("FAIL %s_start: ready/busy/done/err/cpu_rst=%b need 11001", name, {rx_ready, busy, done, err, cpu_rst});
    if ({rx_ready, busy, done, err, cpu_rst} !== 5'b11001) failures++;
  endtask

  task automatic run_image(input string name, input logic [31:0] words[$], input int n,
                           input logic [7:0] ck_xor, input int maxgap, input bit pulse);
    logic [7:0] q[$];
    logic [7:0] x, bt;
    logic [15:0] n16;
    bit ok;
    int nw, sa;
    n16 = 16'(n);
    x = '0;
    q.push_back(n16[7:0]);
    q.push_back(n16[15:8]);
    nw = (n <= CAP) ? n : 0;
    for (int i = 0; i < nw; i++)
      for (int b = 0; b < 4; b++) begin
        bt = words[i][8*b +: 8];
        q.push_back(bt);
        x ^= bt;
      end
    if (CK && n <= CAP) q.push_back(x ^ ck_xor);
    ok = (n <= CAP) && (!CK || ck_xor == 8'h00);
    sa = (pulse && nw > 0) ? int'($urandom_range(2, 1 + 4*nw)) : -1;
    got_addr.delete(); got_data.delete();
    do_start(name);
    foreach (q[i]) send_byte(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, i == sa);
    @(negedge clk); rx_valid = 1'b0;
    checks++;
    if ({done, err, cpu_rst, busy, rx_ready} !== {ok, !ok, !ok, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s_status: done/err/cpu_rst/busy/ready=%b need %b", name,
               {done, err, cpu_rst, busy, rx_ready}, {ok, !ok, !ok, 1'b0, 1'b0});
    end
    if (!CK && nw > 0) begin
      checks++;
      if ({we, addr} !== {1'b1, ADDR_W'(nw - 1)}) begin
        failures++;
        $display("FAIL %s_last_we: we=%b addr=%0d need we=1 addr=%0d", name, we, addr, nw - 1);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_addr.size() != nw) begin
      failures++;
      $display("FAIL %s_nwrites: got %0d writes need %0d", name, got_addr.size(), nw);
    end else
      for (int i = 0; i < nw; i++) begin
        checks++;
        if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== words[i]) begin
          failures++;
          $display("FAIL %s_write%0d: addr=%0d data=%h need addr=%0d data=%h", name, i,
                   got_addr[i], got_data[i], i, words[i]);
        end
      end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, we, addr, wdata, cpu_rst, busy, done, err} !== {2'b00, ADDR_W'(0), 32'h0, 4'b1000}) begin
      failures++;
      $display("FAIL reset_values: ready=%b we=%b addr=%0d wdata=%h cpu_rst=%b busy=%b done=%b err=%b",
               rx_ready, we, addr, wdata, cpu_rst, busy, done, err);
    end
    rst_n = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h5A;
    repeat (4) @(negedge clk);
    checks++;
    if ({rx_ready, busy, got_addr.size() == 0} !== 3'b001) begin
      failures++;
      $display("FAIL idle_backpressure: ready=%b busy=%b writes=%0d need 0 0 0", rx_ready, busy, got_addr.size());
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_spec_image();
    logic [31:0] w[$];
    w = '{32'h00500093, 32'h00A00113};
    run_image("spec", w, 2, 8'h00, 0, 1'b0);
  endtask

`ifdef IMEM_LOADER_CKSUM_EN
  task automatic test_bad_cksum();
    logic [31:0] w[$];
    w = '{32'h00500093, 32'h00A00113};
    run_image("badck", w, 2, 8'h01, 0, 1'b0);
  endtask
`endif

  task automatic test_zero_len();
    logic [31:0] w[$];
    run_image("zero", w, 0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [31:0] w[$];
    run_image("ovf", w, CAP + 1, 8'h00, 0, 1'b0);
  endtask

  task automatic test_max();
    logic [31:0] w[$];
    for (int i = 0; i < CAP; i++) w.push_back($urandom);
    run_image("max", w, CAP, 8'h00, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    int n;
    for (int it = 0; it < 6; it++) begin
      w.delete();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_image("rand", w, n, 8'h00, 5, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    logic [7:0] q[$];
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    q = '{8'd3, 8'd0};
    for (int i = 0; i < 2; i++) for (int b = 0; b < 4; b++) q.push_back(w[i][8*b +: 8]);
    got_addr.delete(); got_data.delete();
    do_start("rstmid");
    for (int i = 0; i < 7; i++) send_byte(q[i], 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_ready, we, addr, wdata, cpu_rst, busy, done, err} !== {2'b00, ADDR_W'(0), 32'h0, 4'b1000}) begin
      failures++;
      $display("FAIL rstmid_values: ready=%b we=%b addr=%0d wdata=%h cpu_rst=%b busy=%b done=%b err=%b",
               rx_ready, we, addr, wdata, cpu_rst, busy, done, err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_addr.size() != 1 || got_data[0] !== w[0] || got_addr[0] !== ADDR_W'(0)) begin
      failures++;
      $display("FAIL rstmid_writes: got %0d writes need 1 (word0=%h)", got_addr.size(), w[0]);
    end
    rx_valid = 1'b0;
    rst_n = 1'b1;
    w.delete();
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    run_image("reload", w, 3, 8'h00, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_spec_image();
`ifdef IMEM_LOADER_CKSUM_EN
    test_bad_cksum();
`endif
    test_zero_len();
    test_overflow();
    test_max();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
